alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_alu.sv | 32 +++
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU op-code constants and FSM state type for
// the alu_arbiter slice.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W       = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOR = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: purely combinational ALU datapath shared by all
// requesters. Unknown op codes produce a zero result.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    // Decode the op code; add/sub wrap naturally at DATA_W bits.
    always_comb begin
        // NOTE: the default assignment up front guarantees every path drives result_o, so no latch is inferred.
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE -> EXEC -> RESP
// handshake. Operands are latched on accept, evaluated for one cycle, and the
// registered result is held until the granted requester consumes it.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; when it is
// undefined requester 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*OP_W-1:0]   req_op,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_zero,
    output logic                   busy,
    output logic [15:0]            ops_done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [OP_W-1:0]   op_q;
    logic              grant_q;
    logic              zero_q;
    logic [15:0]       ops_done_q;

    logic              win_any;
    logic              win_idx;
    logic              accept;
    logic              complete;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        win_any = |req_valid;
        if (req_valid[0] && req_valid[1]) begin
            win_idx = ~last_q;
        end else begin
            win_idx = ~req_valid[0];
        end
    end

    // Last-grant pointer; it only moves when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= win_idx;
        end
    end
`else
    // Fixed priority pick: requester 0 wins whenever it is valid.
    always_comb begin
        win_any = |req_valid;
        win_idx = ~req_valid[0];
    end
`endif

    assign accept   = (state_q == ST_IDLE) && win_any;
    assign complete = (state_q == ST_RESP) && rsp_ready[grant_q];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: EXEC lasts one cycle, RESP waits for the granted consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_any)  state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (complete) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Output decode: handshakes and busy follow the current state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_q != ST_IDLE);
        if (state_q == ST_IDLE && win_any) begin
            req_ready[win_idx] = 1'b1;
        end
        if (state_q == ST_RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    // Operand capture on accept so later input changes cannot disturb the operation.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; they are only consumed after an accept has loaded them.
        if (accept) begin
            a_q  <= req_a[int'(win_idx)*DATA_W +: DATA_W];
            b_q  <= req_b[int'(win_idx)*DATA_W +: DATA_W];
            op_q <= req_op[int'(win_idx)*OP_W +: OP_W];
        end
    end

    // Grant index and registered ALU result; result is captured at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= win_idx;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    // Completed-response counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_q <= '0;
        end else if (complete) begin
            ops_done_q <= ops_done_q + 16'd1;
        end
    end

    alu_arbiter_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Works for both the
// fixed-priority build and the ALU_ARB_RR_EN build.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        busy;
    logic [15:0] ops_done;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [15:0] m_ops;
    int          m_last;

    // stimulus slots, one per requester
    logic [31:0] sa  [2];
    logic [31:0] sb  [2];
    logic [3:0]  sop [2];

    typedef struct {
        logic [1:0]  vmask;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_r;
        logic        exp_z;
    } vec_t;

    vec_t vecs [12];

    alu_arbiter #(.DATA_W(32), .NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_winner(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_ARB_RR_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_ops  = '0;
        m_last = 1;
    endtask

    task automatic drive_slots(input logic [1:0] vmask);
        req_a     = {sa[1], sa[0]};
        req_b     = {sb[1], sb[0]};
        req_op    = {sop[1], sop[0]};
        req_valid = vmask;
    endtask

    // One full operation; entered and left at a falling edge with the DUT idle.
    task automatic run_txn(input logic [1:0] vmask, input logic [31:0] exp_r, input logic exp_z, input string tag);
        int         w;
        logic [1:0] oh;
        w  = model_winner(vmask);
        oh = (w == 0) ? 2'b01 : 2'b10;
        drive_slots(vmask);
        #1;
        check({tag, "/req_ready"}, 64'(req_ready), 64'(oh));
        @(posedge clk);
        m_last = w;
        @(negedge clk);
        req_valid = '0;
        req_a     = ~req_a;
        req_b     = ~req_b;
        req_op    = ~req_op;
        check({tag, "/exec_busy"}, 64'(busy), 64'(1));
        check({tag, "/exec_rsp_valid"}, 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check({tag, "/rsp_valid"}, 64'(rsp_valid), 64'(oh));
        check({tag, "/rsp_result"}, 64'(rsp_result), 64'(exp_r));
        check({tag, "/rsp_zero"}, 64'(rsp_zero), 64'(exp_z));
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
        m_ops     = m_ops + 16'd1;
        check({tag, "/ops_done"}, 64'(ops_done), 64'(m_ops));
        check({tag, "/idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [1:0]  exp_grant;
        logic [1:0]  got_grant;
        logic [1:0]  vm;
        logic [31:0] er;
        int          w;
        int          n;

        vecs[0]  = '{2'b01, 32'd5,         32'd3,         4'b0000, 32'd8,         1'b0};
        vecs[1]  = '{2'b10, 32'h7,         32'h7,         4'b0001, 32'd0,         1'b1};
        vecs[2]  = '{2'b01, 32'd1,         32'd1,         4'b1111, 32'd0,         1'b1};
        vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0,         1'b1};
        vecs[4]  = '{2'b01, 32'd0,         32'd1,         4'b0001, 32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010, 32'hF000_F000, 1'b0};
        vecs[6]  = '{2'b01, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'b0011, 32'hFFFF_F0F0, 1'b0};
        vecs[7]  = '{2'b10, 32'hAAAA_5555, 32'hFFFF_0000, 4'b0100, 32'h5555_5555, 1'b0};
        vecs[8]  = '{2'b01, 32'd0,         32'd0,         4'b0101, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'h1234_5678, 32'h1234_5678, 4'b0100, 32'd0,         1'b1};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'd0,         4'b0101, 32'd0,         1'b1};
        vecs[11] = '{2'b10, 32'd1,         32'd2,         4'b0110, 32'd0,         1'b1};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        m_ops     = '0;
        m_last    = 1;

        // reset state
        do_reset();
        check("reset/req_ready", 64'(req_ready), 64'(0));
        check("reset/rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset/rsp_result", 64'(rsp_result), 64'(0));
        check("reset/rsp_zero", 64'(rsp_zero), 64'(0));
        check("reset/busy", 64'(busy), 64'(0));
        check("reset/ops_done", 64'(ops_done), 64'(0));

        // directed single-requester vectors
        foreach (vecs[i]) begin
            for (int j = 0; j < 2; j++) begin
                sa[j]  = $urandom;
                sb[j]  = $urandom;
                sop[j] = 4'($urandom_range(0, 15));
            end
            w      = vecs[i].vmask[1] ? 1 : 0;
            sa[w]  = vecs[i].a;
            sb[w]  = vecs[i].b;
            sop[w] = vecs[i].op;
            run_txn(vecs[i].vmask, vecs[i].exp_r, vecs[i].exp_z, $sformatf("vec%0d", i));
        end

        // both requesters held valid from reset: grant order
        do_reset();
        for (int j = 0; j < 2; j++) begin
            sa[j]  = 32'(j + 10);
            sb[j]  = 32'd1;
            sop[j] = 4'b0000;
        end
        drive_slots(2'b11);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b01;
`endif
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 10) begin
                @(negedge clk);
                n++;
            end
            got_grant = req_ready;
            check($sformatf("arb/grant%0d", k), 64'(got_grant), 64'(exp_grant));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("arb/stall_ready%0d", k), 64'(req_ready), 64'(0));
            @(negedge clk);
            check($sformatf("arb/rsp_valid%0d", k), 64'(rsp_valid), 64'(exp_grant));
            check($sformatf("arb/result%0d", k), 64'(rsp_result),
                  64'((exp_grant == 2'b01) ? 32'd11 : 32'd12));
            rsp_ready = got_grant;
            @(negedge clk);
            rsp_ready = '0;
            m_ops     = m_ops + 16'd1;
            check($sformatf("arb/ops_done%0d", k), 64'(ops_done), 64'(m_ops));
        end
        req_valid = '0;
        m_last    = 1;

        // response backpressure on requester 1 while requester 0 waits
        sa[1]  = 32'h7;
        sb[1]  = 32'h7;
        sop[1] = 4'b0001;
        sa[0]  = 32'h55;
        sb[0]  = 32'h1;
        sop[0] = 4'b0000;
        drive_slots(2'b10);
        #1;
        check("bp/req_ready", 64'(req_ready), 64'(2'b10));
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp/rsp_valid%0d", k), 64'(rsp_valid), 64'(2'b10));
            check($sformatf("bp/result%0d", k), 64'(rsp_result), 64'(0));
            check($sformatf("bp/zero%0d", k), 64'(rsp_zero), 64'(1));
            check($sformatf("bp/req_ready%0d", k), 64'(req_ready), 64'(0));
            rsp_ready = 2'b01;
            @(negedge clk);
        end
        check("bp/ops_held", 64'(ops_done), 64'(m_ops));
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = '0;
        req_valid = '0;
        m_ops     = m_ops + 16'd1;
        m_last    = 1;
        check("bp/ops_done", 64'(ops_done), 64'(m_ops));
        check("bp/busy", 64'(busy), 64'(0));

        // randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            vm = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                sa[j]  = $urandom;
                sb[j]  = $urandom;
                sop[j] = 4'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) sb[j] = sa[j];
            end
            w  = model_winner(vm);
            er = model_alu(sa[w], sb[w], sop[w]);
            run_txn(vm, er, (er == 32'd0), $sformatf("rand%0d", i));
        end

        // reset while a response is pending
        sa[0]  = 32'd9;
        sb[0]  = 32'd1;
        sop[0] = 4'b0000;
        drive_slots(2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rst_resp/pre_valid", 64'(rsp_valid), 64'(2'b01));
        rst = 1'b1;
        @(negedge clk);
        check("rst_resp/rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_resp/busy", 64'(busy), 64'(0));
        check("rst_resp/ops_done", 64'(ops_done), 64'(0));
        check("rst_resp/rsp_result", 64'(rsp_result), 64'(0));
        check("rst_resp/rsp_zero", 64'(rsp_zero), 64'(0));
        rst    = 1'b0;
        m_ops  = '0;
        m_last = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_resp/late%0d", k), 64'(rsp_valid), 64'(0));
        end

        // reset while executing
        drive_slots(2'b10);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_exec/busy", 64'(busy), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_exec/late%0d", k), 64'(rsp_valid), 64'(0));
        end
        check("rst_exec/ops_done", 64'(ops_done), 64'(0));

        // counter wrap: preload near the top, then complete two operations
        force dut.ops_done_q = 16'hFFFE;
        @(negedge clk);
        release dut.ops_done_q;
        m_ops = 16'hFFFE;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sa[0]  = 32'd2;
            sb[0]  = 32'd2;
            sop[0] = 4'b0010;
            run_txn(2'b01, 32'd2, 1'b0, $sformatf("wrap%0d", k));
        end
        check("wrap/final", 64'(ops_done), 64'(16'h0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
